logic_eval_pipe: RTL

// - Parametrised, registered successor to the 1-bit x/y gate evaluator.
// - Evaluates one of four 3-input bitwise functions over WIDTH-bit operands a, b, c.
// - Accepts operands on a valid/ready input; queues results in a DEPTH-entry FIFO drained by a valid/ready output.
// - Keeps a saturating running count of '1' bits across all accepted results, for lab self-check.

---
 rtl/logic_eval_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/logic_eval_pipe.sv
// logic_eval_pipe
//   Registered, parametrised 3-input bitwise function evaluator. Each accepted
//   beat (a, b, c, op) is evaluated combinationally and written into a
//   DEPTH-entry result FIFO. The FIFO head is offered on a valid/ready output.
//   A saturating running popcount of every accepted result is kept for
//   self-check.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (pointers, fill, statistic)
//   clr         synchronous clear of FIFO and statistic, wins over accept/pop
//   in_valid    operand beat valid
//   in_ready    beat can be accepted (not full and not clearing)
//   in_op       function select: 0 ~c^(a&b), 1 a&b, 2 majority, 3 a^b^c
//   in_a/b/c    WIDTH-bit operands
//   out_valid   FIFO head valid
//   out_ready   consumer takes the head
//   out_data    FIFO head result (don't-care while out_valid=0)
//   fill_level  entries held, 0..DEPTH
//   ones_count  saturating sum of popcount over accepted results
module logic_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         ones_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int POP_W  = $clog2(WIDTH + 1);
  // One spare bit above the wider of the two addends so the sum never wraps
  // before the saturation compare.
  localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bitwise function selected by op.
  function automatic logic [WIDTH-1:0] eval_fn(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'd0:    r = ~c ^ (a & b);
      2'd1:    r = a & b;
      2'd2:    r = (a & b) | (a & c) | (b & c);
      2'd3:    r = a ^ b ^ c;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Number of set bits in a result word.
  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = {POP_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              accept_s;
  logic              pop_s;
  logic [WIDTH-1:0]  result_s;
  logic [SUM_W-1:0]  sum_s;
  logic [CNT_W-1:0]  cnt_next_s;

  assign in_ready   = (fill_r != FILL_W'(DEPTH)) && !clr;
  assign out_valid  = (fill_r != {FILL_W{1'b0}});
  assign out_data   = mem_r[rd_ptr_r];
  assign fill_level = fill_r;
  assign ones_count = cnt_r;

  // Handshakes, result evaluation and saturating statistic update.
  always_comb begin
    accept_s = in_valid && in_ready;
    pop_s    = out_valid && out_ready;
    result_s = eval_fn(in_op, in_a, in_b, in_c);
    sum_s    = SUM_W'(cnt_r) + SUM_W'(popcount(result_s));
    if (sum_s > SUM_W'(CNT_MAX)) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = sum_s[CNT_W-1:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_W'(1);
        2'b01:   fill_r <= fill_r - FILL_W'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Saturating popcount statistic; untouched by pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_next_s;
    end
  end

  // Result storage; deliberately not reset, contents only read while valid.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= result_s;
    end
  end

endmodule
